// File: rtl/mmio_console_pkg.sv
// Shared constants and types for the MMIO console responder.
package mmio_console_pkg;

  // Bus addresses decoded by the console (full-word match).
  localparam logic [31:0] MMIO_PRINT_ADDR  = 32'h1000_0000;
  localparam logic [31:0] MMIO_DONE_ADDR   = 32'h1000_0004;
  localparam logic [31:0] MMIO_STATUS_ADDR = 32'h1000_0008;

  // STATUS register bit positions.
  localparam int STATUS_DONE_BIT     = 0;
  localparam int STATUS_OVF_BIT      = 1;
  localparam int STATUS_NOT_FULL_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 8;
  localparam int STATUS_COUNT_MSB    = 15;

  // Console life cycle: accept prints, drain after DONE, then halt.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } console_state_e;

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module mmio_console_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Head word is forced to zero while empty so stale storage never shows.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) begin
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/mmio_console.sv
// CPU-side MMIO console: decodes PRINT/DONE/STATUS, buffers PRINT words
// onto a valid/ready stream and reports completion once everything drained.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] memory_address,
  input  logic            memory_write_enable,
  input  logic [XLEN-1:0] memory_write_data,
  input  logic            memory_read_enable,
  output logic [XLEN-1:0] memory_read_data,
  output logic            mmio_hit,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  input  logic            out_ready,
  output logic            done_o,
  output logic [XLEN-1:0] exit_code
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [XLEN-1:0] PRINT_A  = XLEN'(MMIO_PRINT_ADDR);
  localparam logic [XLEN-1:0] DONE_A   = XLEN'(MMIO_DONE_ADDR);
  localparam logic [XLEN-1:0] STATUS_A = XLEN'(MMIO_STATUS_ADDR);

  console_state_e  state_q, state_d;
  logic [XLEN-1:0] exit_q, exit_d;
  logic            ovf_q, ovf_d;

  logic            print_hit, done_hit, status_hit;
  logic            print_store, done_store, status_store;
  logic            fifo_full, fifo_empty, pop;
  logic [AW:0]     fifo_count;
  logic [XLEN-1:0] status_word;

  assign print_hit  = (memory_address == PRINT_A);
  assign done_hit   = (memory_address == DONE_A);
  assign status_hit = (memory_address == STATUS_A);
  assign mmio_hit   = print_hit | done_hit | status_hit;

  // PRINT and DONE only act while running; STATUS clears work in any state.
  assign print_store  = memory_write_enable & print_hit  & (state_q == RUN);
  assign done_store   = memory_write_enable & done_hit   & (state_q == RUN);
  assign status_store = memory_write_enable & status_hit;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  mmio_console_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (print_store),
    .push_data_i (memory_write_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Next state, exit-code capture and sticky overflow flag.
  always_comb begin
    state_d = state_q;
    exit_d  = exit_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        if (done_store) begin
          state_d = DRAIN;
          exit_d  = memory_write_data;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = HALT;
        end else begin
          state_d = DRAIN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    if (status_store && memory_write_data[STATUS_OVF_BIT]) begin
      ovf_d = 1'b0;
    end else if (print_store && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      exit_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exit_q  <= exit_d;
      ovf_q   <= ovf_d;
    end
  end

  assign done_o    = (state_q == HALT);
  assign exit_code = exit_q;

  // Load data: STATUS is assembled from registers, PRINT/DONE read as zero.
  always_comb begin
    status_word = '0;
    status_word[STATUS_DONE_BIT]     = done_o;
    status_word[STATUS_OVF_BIT]      = ovf_q;
    status_word[STATUS_NOT_FULL_BIT] = ~fifo_full;
    status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(fifo_count);
    if (memory_read_enable && status_hit) begin
      memory_read_data = status_word;
    end else begin
      memory_read_data = '0;
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Directed, table-driven bench for mmio_console.
module tb_mmio_console;
  import mmio_console_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memory_address;
  logic        memory_write_enable;
  logic [31:0] memory_write_data;
  logic        memory_read_enable;
  logic [31:0] memory_read_data;
  logic        mmio_hit;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        done_o;
  logic [31:0] exit_code;

  int checks = 0;
  int errors = 0;
  int vidx   = 0;

  localparam logic [31:0] N = 32'h0000_0100;
  localparam logic [31:0] P = MMIO_PRINT_ADDR;
  localparam logic [31:0] D = MMIO_DONE_ADDR;
  localparam logic [31:0] S = MMIO_STATUS_ADDR;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic        rdy;
    logic        hit;
    logic [31:0] rd;
    logic        valid;
    logic [31:0] data;
    logic        done;
    logic [31:0] exitc;
  } vec_t;

  vec_t vq[$];

  mmio_console #(.XLEN(32), .DEPTH(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .memory_address      (memory_address),
    .memory_write_enable (memory_write_enable),
    .memory_write_data   (memory_write_data),
    .memory_read_enable  (memory_read_enable),
    .memory_read_data    (memory_read_data),
    .mmio_hit            (mmio_hit),
    .out_valid           (out_valid),
    .out_data            (out_data),
    .out_ready           (out_ready),
    .done_o              (done_o),
    .exit_code           (exit_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, vidx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic re, input logic rdy, input logic hit, input logic [31:0] rd,
                     input logic v, input logic [31:0] d, input logic dn, input logic [31:0] ec);
    vq.push_back('{r, a, w, wd, re, rdy, hit, rd, v, d, dn, ec});
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic re, input logic rdy);
    rst                 = r;
    memory_address      = a;
    memory_write_enable = w;
    memory_write_data   = wd;
    memory_read_enable  = re;
    out_ready           = rdy;
  endtask

  initial begin
    logic [31:0] drain_exp [7];
    logic [31:0] got [$];

    drive(1'b1, N, 1'b0, 32'd0, 1'b0, 1'b0);

    // Test 1: reset, single PRINT popped immediately.
    add(1'b1, N, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,      1'b0, 32'd0,  1'b0, 32'd0);
    add(1'b0, P, 1'b1, 32'd42, 1'b0, 1'b1, 1'b1, 32'd0,      1'b1, 32'd42, 1'b0, 32'd0);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'h104,    1'b0, 32'd0,  1'b0, 32'd0);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'h004,    1'b0, 32'd0,  1'b0, 32'd0);
    // Test 2: nine PRINTs into an 8-deep FIFO with the sink stalled.
    for (int k = 1; k <= 9; k++) begin
      add(1'b0, P, 1'b1, 32'(k), 1'b0, 1'b0, 1'b1, 32'd0,    1'b1, 32'd1,  1'b0, 32'd0);
    end
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'h802,    1'b1, 32'd1,  1'b0, 32'd0);
    // Write-1-to-clear overflow.
    add(1'b0, S, 1'b1, 32'd2,  1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd1,  1'b0, 32'd0);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'h800,    1'b1, 32'd1,  1'b0, 32'd0);
    // Test 3: PRINT into the full FIFO while popping is accepted.
    add(1'b0, P, 1'b1, 32'd77, 1'b0, 1'b1, 1'b1, 32'd0,      1'b1, 32'd2,  1'b0, 32'd0);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'h800,    1'b1, 32'd2,  1'b0, 32'd0);
    drain_exp = '{32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd77};
    for (int k = 0; k < 7; k++) begin
      add(1'b0, N, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0,     1'b1, drain_exp[k], 1'b0, 32'd0);
    end
    add(1'b0, N, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,      1'b0, 32'd0,  1'b0, 32'd0);
    // Test 4: DONE waits for queued words, later stores ignored.
    add(1'b0, P, 1'b1, 32'd5,  1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd5,  1'b0, 32'd0);
    add(1'b0, P, 1'b1, 32'd6,  1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd5,  1'b0, 32'd0);
    add(1'b0, D, 1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd5,  1'b0, 32'd3);
    add(1'b0, N, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0,      1'b1, 32'd5,  1'b0, 32'd3);
    add(1'b0, N, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,      1'b1, 32'd6,  1'b0, 32'd3);
    add(1'b0, N, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,      1'b0, 32'd0,  1'b0, 32'd3);
    add(1'b0, N, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,      1'b0, 32'd0,  1'b1, 32'd3);
    add(1'b0, P, 1'b1, 32'd8,  1'b0, 1'b0, 1'b1, 32'd0,      1'b0, 32'd0,  1'b1, 32'd3);
    add(1'b0, D, 1'b1, 32'd4,  1'b0, 1'b0, 1'b1, 32'd0,      1'b0, 32'd0,  1'b1, 32'd3);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'h005,    1'b0, 32'd0,  1'b1, 32'd3);
    add(1'b0, D, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'd0,      1'b0, 32'd0,  1'b1, 32'd3);
    // Test 5: DONE with empty FIFO halts two cycles after the store.
    add(1'b1, N, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,      1'b0, 32'd0,  1'b0, 32'd0);
    add(1'b0, D, 1'b1, 32'd0,  1'b0, 1'b1, 1'b1, 32'd0,      1'b0, 32'd0,  1'b0, 32'd0);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'h004,    1'b0, 32'd0,  1'b1, 32'd0);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'h005,    1'b0, 32'd0,  1'b1, 32'd0);
    // Test 6: reset in DRAIN with three queued words.
    add(1'b1, N, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,      1'b0, 32'd0,  1'b0, 32'd0);
    add(1'b0, P, 1'b1, 32'd11, 1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd11, 1'b0, 32'd0);
    add(1'b0, P, 1'b1, 32'd12, 1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd11, 1'b0, 32'd0);
    add(1'b0, P, 1'b1, 32'd13, 1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd11, 1'b0, 32'd0);
    add(1'b0, D, 1'b1, 32'd9,  1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd11, 1'b0, 32'd9);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'h304,    1'b1, 32'd11, 1'b0, 32'd9);
    add(1'b1, P, 1'b1, 32'd14, 1'b0, 1'b1, 1'b1, 32'd0,      1'b0, 32'd0,  1'b0, 32'd0);
    add(1'b0, S, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'h004,    1'b0, 32'd0,  1'b0, 32'd0);
    add(1'b0, P, 1'b1, 32'd21, 1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd21, 1'b0, 32'd0);
    add(1'b0, P, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'd0,      1'b1, 32'd21, 1'b0, 32'd0);
    add(1'b0, N, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,      1'b1, 32'd21, 1'b0, 32'd0);

    foreach (vq[i]) begin
      vidx = i;
      drive(vq[i].rst, vq[i].addr, vq[i].we, vq[i].wd, vq[i].re, vq[i].rdy);
      #1;
      chk("mmio_hit", 32'(mmio_hit), 32'(vq[i].hit));
      chk("read_data", memory_read_data, vq[i].rd);
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(vq[i].valid));
      chk("out_data", out_data, vq[i].data);
      chk("done_o", 32'(done_o), 32'(vq[i].done));
      chk("exit_code", exit_code, vq[i].exitc);
    end

    // Hand sequence: queue words, DONE, then drain with a bounded wait.
    vidx = 1000;
    drive(1'b1, N, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, P, 1'b1, 32'd100 + 32'(k), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, D, 1'b1, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, N, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int c = 0; c < 20 && !done_o; c++) begin
      if (out_valid) got.push_back(out_data);
      @(posedge clk); #1;
    end
    chk("seq_done_within_bound", 32'(done_o), 32'd1);
    chk("seq_word_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("seq_word", (k < got.size()) ? got[k] : 32'hDEAD_BEEF, 32'd100 + 32'(k));
    end
    chk("seq_exit_code", exit_code, 32'd7);
    chk("seq_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
